press_arbiter: RTL and testbench

- Sits between the two player-button synchronizers and the tug-of-war playfield logic.
- Takes each player's synchronized button level and debounces it.
- Converts each accepted press into exactly one request.
- Arbitrates the two requests so the playfield sees at most one move pulse per cycle, plus a tie indication.
- Gates all moves with a game-enable so no moves occur after a win.

---
 rtl/press_pkg.sv | 16 +
 rtl/btn_conditioner.sv | 76 +++++++
 rtl/press_arbiter.sv | 97 +++++++++
 tb/tb_press_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types for the tug-of-war press arbiter: conditioner FSM states and tie priority side.
// Optional tie alternation is selected by PRESS_ARB_TIE_ALT_EN in press_arbiter.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2
  } btn_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

endpackage

// File: rtl/btn_conditioner.sv
// Debounces one synchronized button level and emits a single-cycle req per accepted press.
// req rises in the cycle after the DEBOUNCE_CYC-th consecutive high sample; holding never repeats.
module btn_conditioner
  import press_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn) begin
          if (DEBOUNCE_CYC == 1) begin
            state_d = HELD;
            req_d   = 1'b1;
          end else begin
            state_d = ARM;
            cnt_d   = CW'(1);
          end
        end
      end
      ARM: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // cnt holds at its final value so it can never wrap while HELD
          state_d = HELD;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/press_arbiter.sv
// Two-player press arbiter: debounced presses become registered move/tie pulses, gated by enable.
// Define PRESS_ARB_TIE_ALT_EN to grant ties alternately (starting LEFT) instead of suppressing moves.
module press_arbiter
  import press_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic l_btn,
  input  logic r_btn,
  input  logic enable,
  output logic l_move,
  output logic r_move,
  output logic tie
);

  logic l_req, r_req;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_l_cond (
    .clk   (clk),
    .reset (reset),
    .btn   (l_btn),
    .req   (l_req)
  );

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_r_cond (
    .clk   (clk),
    .reset (reset),
    .btn   (r_btn),
    .req   (r_req)
  );

  logic l_move_q, l_move_d;
  logic r_move_q, r_move_d;
  logic tie_q, tie_d;

`ifdef PRESS_ARB_TIE_ALT_EN
  side_t prio_q, prio_d;
`endif

  // A req arriving while disabled is simply dropped; the conditioner is already in HELD.
  always_comb begin
    l_move_d = 1'b0;
    r_move_d = 1'b0;
    tie_d    = 1'b0;
`ifdef PRESS_ARB_TIE_ALT_EN
    prio_d   = prio_q;
`endif
    if (enable) begin
      case ({l_req, r_req})
        2'b10: l_move_d = 1'b1;
        2'b01: r_move_d = 1'b1;
        2'b11: begin
          tie_d = 1'b1;
`ifdef PRESS_ARB_TIE_ALT_EN
          if (prio_q == LEFT) begin
            l_move_d = 1'b1;
            prio_d   = RIGHT;
          end else begin
            r_move_d = 1'b1;
            prio_d   = LEFT;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_move_q <= 1'b0;
      r_move_q <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      l_move_q <= l_move_d;
      r_move_q <= r_move_d;
      tie_q    <= tie_d;
    end
  end

`ifdef PRESS_ARB_TIE_ALT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= LEFT;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  assign l_move = l_move_q;
  assign r_move = r_move_q;
  assign tie    = tie_q;

endmodule

// File: tb/tb_press_arbiter.sv
// Directed bench for press_arbiter with DEBOUNCE_CYC=4; outputs are sampled on the falling edge.
module tb_press_arbiter;

  logic clk;
  logic reset;
  logic l_btn;
  logic r_btn;
  logic enable;
  logic l_move;
  logic r_move;
  logic tie;

  int n_assert;
  int n_fail;

  press_arbiter #(.DEBOUNCE_CYC(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .l_btn  (l_btn),
    .r_btn  (r_btn),
    .enable (enable),
    .l_move (l_move),
    .r_move (r_move),
    .tie    (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PRESS_ARB_TIE_ALT_EN
  localparam logic [2:0] TIE1 = 3'b101;
  localparam logic [2:0] TIE2 = 3'b011;
`else
  localparam logic [2:0] TIE1 = 3'b001;
  localparam logic [2:0] TIE2 = 3'b001;
`endif

  // Expected value is {l_move, r_move, tie}.
  task automatic check(input string tag, input int cyc, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {l_move, r_move, tie};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: {l_move,r_move,tie} got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Advance n cycles, checking after each rising edge; pulse_val expected only at cycle pulse_at.
  task automatic run(input string tag, input int n, input int pulse_at, input logic [2:0] pulse_val);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check(tag, i, (i == pulse_at) ? pulse_val : 3'b000);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    l_btn    = 1'b0;
    r_btn    = 1'b0;
    enable   = 1'b1;

    run("reset_state", 2, 0, 3'b000);
    reset = 1'b0;
    run("idle", 2, 0, 3'b000);

    // Left press held 6 samples: move after the 5th edge.
    l_btn = 1'b1;
    run("left_press", 6, 5, 3'b100);
    l_btn = 1'b0;
    run("left_release", 3, 0, 3'b000);

    // Right 3-sample glitch, then a 4-sample press.
    r_btn = 1'b1;
    run("right_glitch", 3, 0, 3'b000);
    r_btn = 1'b0;
    run("right_glitch_low", 1, 0, 3'b000);
    r_btn = 1'b1;
    run("right_press", 4, 0, 3'b000);
    r_btn = 1'b0;
    run("right_fire", 3, 1, 3'b010);

    // Two simultaneous presses.
    l_btn = 1'b1;
    r_btn = 1'b1;
    run("tie1", 5, 5, TIE1);
    l_btn = 1'b0;
    r_btn = 1'b0;
    run("tie1_release", 3, 0, 3'b000);
    l_btn = 1'b1;
    r_btn = 1'b1;
    run("tie2", 5, 5, TIE2);
    l_btn = 1'b0;
    r_btn = 1'b0;
    run("tie2_release", 3, 0, 3'b000);

    // Press while disabled is discarded; re-enable with button held must not fire.
    enable = 1'b0;
    l_btn  = 1'b1;
    run("disabled_hold", 10, 0, 3'b000);
    enable = 1'b1;
    run("enable_still_held", 5, 0, 3'b000);
    l_btn = 1'b0;
    run("enable_release", 2, 0, 3'b000);
    l_btn = 1'b1;
    run("repress", 4, 0, 3'b000);
    l_btn = 1'b0;
    run("repress_fire", 3, 1, 3'b100);

    // Reset mid-press discards the partial count.
    l_btn = 1'b1;
    run("pre_reset", 2, 0, 3'b000);
    reset = 1'b1;
    run("mid_reset", 1, 0, 3'b000);
    reset = 1'b0;
    run("post_reset", 5, 5, 3'b100);
    l_btn = 1'b0;
    run("post_reset_release", 2, 0, 3'b000);

    // Long hold: exactly one move.
    l_btn = 1'b1;
    run("long_hold", 40, 5, 3'b100);
    l_btn = 1'b0;
    run("long_release", 3, 0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
